// File: rtl/writeback_regfile.sv
// Architectural integer register file fed by the writeback stage, with two bypassed
// combinational read ports, a 4-phase debug access port and a retired-write counter.
`timescale 1ns/1ps
module writeback_regfile #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RD_W,
  input  logic [XLEN-1:0] ResultW,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata,
  output logic [31:0]     wr_count
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} dbg_state_e;

  dbg_state_e      state_q, state_d;
  logic [XLEN-1:0] regs_q [NREG];
  logic            dbg_we_q;
  logic [AW-1:0]   dbg_addr_q;
  logic [XLEN-1:0] dbg_wdata_q;
  logic            pipe_we;
  logic            capture;
  logic            dbg_rd_en;
  logic            dbg_wr_en;
  logic [XLEN-1:0] dbg_rval;

  function automatic logic [XLEN-1:0] read_mux(input logic [AW-1:0]   addr,
                                               input logic [XLEN-1:0] stored,
                                               input logic            we,
                                               input logic [AW-1:0]   waddr,
                                               input logic [XLEN-1:0] wdata);
    if (addr == '0) return '0;
    if (BYPASS && we && (waddr == addr)) return wdata;
    return stored;
  endfunction

  assign pipe_we = RegWriteW && (RD_W != '0);

  always_comb begin
    RD1      = '0;
    RD2      = '0;
    dbg_rval = read_mux(dbg_addr_q, regs_q[dbg_addr_q], RegWriteW, RD_W, ResultW);
    if (!rst) begin
      RD1 = read_mux(A1, regs_q[A1], RegWriteW, RD_W, ResultW);
      RD2 = read_mux(A2, regs_q[A2], RegWriteW, RD_W, ResultW);
    end
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    dbg_rd_en = 1'b0;
    dbg_wr_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (dbg_req) begin
          capture = 1'b1;
          state_d = StAccess;
        end
      end
      StAccess: begin
        if (!dbg_we_q) begin
          dbg_rd_en = 1'b1;
          state_d   = StDone;
        end else if (!pipe_we) begin
          // A pipeline write never stalls, so a debug write retries until the port is free.
          dbg_wr_en = (dbg_addr_q != '0);
          state_d   = StDone;
        end
      end
      StDone: begin
        if (!dbg_req) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
      dbg_rdata   <= '0;
      dbg_ack     <= 1'b0;
      wr_count    <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        dbg_we_q    <= dbg_we;
        dbg_addr_q  <= dbg_addr;
        dbg_wdata_q <= dbg_wdata;
      end
      if (dbg_rd_en) dbg_rdata <= dbg_rval;
      // Ack rises one cycle into DONE and falls on the edge that sees req released.
      dbg_ack <= (state_q == StDone) && dbg_req;
      if (pipe_we) wr_count <= wr_count + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (pipe_we) begin
      regs_q[RD_W] <= ResultW;
    end else if (dbg_wr_en) begin
      regs_q[dbg_addr_q] <= dbg_wdata_q;
    end
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Scoreboard bench for writeback_regfile: expected values are queued as stimulus is
// driven and popped against DUT outputs at the following negedge.
`timescale 1ns/1ps
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst, RegWriteW, dbg_req, dbg_we;
  logic [4:0]  RD_W, A1, A2, dbg_addr;
  logic [31:0] ResultW, dbg_wdata;
  logic [31:0] RD1, RD2, dbg_rdata, wr_count;
  logic        dbg_ack;
  logic [31:0] nb_rd1, nb_rd2, nb_rdata, nb_count;
  logic        nb_ack;

  int          checks = 0;
  int          errors = 0;
  int          n;
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic [31:0] obs[$];
  logic [31:0] e;
  string       nm;
  logic [31:0] mreg[32];
  logic [31:0] mcount;

  always #5 clk = ~clk;

  writeback_regfile #(.XLEN(32), .NREG(32), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW),
    .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .wr_count(wr_count)
  );

  writeback_regfile #(.XLEN(32), .NREG(32), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW),
    .A1(A1), .A2(A2), .RD1(nb_rd1), .RD2(nb_rd2), .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata), .dbg_ack(nb_ack), .dbg_rdata(nb_rdata),
    .wr_count(nb_count)
  );

  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      foreach (mreg[i]) mreg[i] = '0;
      mcount = '0;
    end else if (RegWriteW && RD_W != 5'd0) begin
      mreg[RD_W] = ResultW;
      mcount     = mcount + 32'd1;
    end
    #1;
  endtask

  task automatic push_exp(input string name, input logic [31:0] v);
    exp_q.push_back(v);
    name_q.push_back(name);
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp && RegWriteW && RD_W == a) return ResultW;
    return mreg[a];
  endfunction

  task automatic test_reset();
    rst = 1'b1; RegWriteW = 1'b1; RD_W = 5'd5; ResultW = 32'h1357; A1 = 5'd5; A2 = 5'd5;
    push_exp("rst_rd1", 32'd0); push_exp("rst_rd2", 32'd0); push_exp("rst_nb_rd1", 32'd0);
    push_exp("rst_wr_count", 32'd0); push_exp("rst_ack", 32'd0); push_exp("rst_rdata", 32'd0);
    push_exp("rst_nb_ack", 32'd0);
    cycle(); cycle();
    @(negedge clk);
    obs = {RD1, RD2, nb_rd1, wr_count, 32'(dbg_ack), dbg_rdata, 32'(nb_ack)};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
    rst = 1'b0; RegWriteW = 1'b0; A1 = 5'd0; A2 = 5'd0;
    cycle();
  endtask

  task automatic test_write_read();
    A1 = 5'd5;
    push_exp("x5_after_rst", 32'd0);
    @(negedge clk);
    obs = {RD1};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
    RegWriteW = 1'b1; RD_W = 5'd5; ResultW = 32'hDEADBEEF; A1 = 5'd0;
    cycle();
    RegWriteW = 1'b0; A1 = 5'd5; A2 = 5'd5;
    push_exp("wr_rd1", 32'hDEADBEEF); push_exp("wr_rd2", 32'hDEADBEEF);
    push_exp("wr_nb_rd1", 32'hDEADBEEF); push_exp("wr_count_1", 32'd1);
    @(negedge clk);
    obs = {RD1, RD2, nb_rd1, wr_count};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
  endtask

  task automatic test_bypass();
    RegWriteW = 1'b1; RD_W = 5'd7; ResultW = 32'h1111;
    cycle();
    ResultW = 32'h1234; A1 = 5'd7; A2 = 5'd7;
    push_exp("byp_rd1", 32'h1234); push_exp("byp_rd2", 32'h1234);
    push_exp("nobyp_rd2", 32'h1111);
    @(negedge clk);
    obs = {RD1, RD2, nb_rd2};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
    cycle();
    RegWriteW = 1'b0;
    push_exp("byp_stored_rd2", 32'h1234); push_exp("nobyp_stored_rd2", 32'h1234);
    push_exp("byp_wr_count", 32'd3);
    @(negedge clk);
    obs = {RD2, nb_rd2, wr_count};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
  endtask

  task automatic test_x0();
    RegWriteW = 1'b1; RD_W = 5'd0; ResultW = 32'hFFFFFFFF; A1 = 5'd0; A2 = 5'd0;
    push_exp("x0_rd1", 32'd0); push_exp("x0_nb_rd1", 32'd0);
    @(negedge clk);
    obs = {RD1, nb_rd1};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
    cycle();
    RegWriteW = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd0; dbg_wdata = 32'hBAD0BAD0;
    n = 0;
    do begin cycle(); n++; end while (!dbg_ack && n < 10);
    dbg_req = 1'b0;
    cycle();
    push_exp("x0_dbg_latency", 32'd3); push_exp("x0_after_dbg_rd1", 32'd0);
    push_exp("x0_wr_count", 32'd3); push_exp("x0_ack_drop", 32'd0);
    @(negedge clk);
    obs = {32'(n), RD1, wr_count, 32'(dbg_ack)};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
  endtask

  task automatic test_dbg_read();
    RegWriteW = 1'b1; RD_W = 5'd3; ResultW = 32'hA5;
    cycle();
    RegWriteW = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd3; dbg_wdata = 32'd0;
    cycle(); n = 1;
    // Captured fields must ignore these late changes.
    dbg_addr = 5'd4; dbg_we = 1'b1; dbg_wdata = 32'hEEEE;
    while (!dbg_ack && n < 10) begin cycle(); n++; end
    push_exp("dbg_rd_latency", 32'd3); push_exp("dbg_rdata", 32'hA5);
    push_exp("dbg_nb_rdata", 32'hA5);
    @(negedge clk);
    obs = {32'(n), dbg_rdata, nb_rdata};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
    cycle();
    push_exp("dbg_ack_held", 32'd1); push_exp("dbg_rdata_held", 32'hA5);
    @(negedge clk);
    obs = {32'(dbg_ack), dbg_rdata};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
    dbg_req = 1'b0;
    cycle();
    A1 = 5'd4;
    push_exp("dbg_ack_drop", 32'd0); push_exp("dbg_late_we_ignored", 32'd0);
    @(negedge clk);
    obs = {32'(dbg_ack), RD1};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
  endtask

  task automatic test_dbg_contention();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd9; dbg_wdata = 32'h55;
    cycle(); n = 1;
    RegWriteW = 1'b1; RD_W = 5'd9; ResultW = 32'h77;
    repeat (3) begin cycle(); n++; end
    RegWriteW = 1'b0;
    while (!dbg_ack && n < 20) begin cycle(); n++; end
    mreg[9] = 32'h55;
    dbg_req = 1'b0;
    cycle();
    A1 = 5'd9;
    push_exp("cont_latency", 32'd6); push_exp("cont_x9", 32'h55);
    push_exp("cont_wr_count", mcount); push_exp("cont_ack_drop", 32'd0);
    @(negedge clk);
    obs = {32'(n), RD1, wr_count, 32'(dbg_ack)};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
  endtask

  task automatic test_reset_mid_access();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 5'd12; dbg_wdata = 32'hCAFE;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0; dbg_req = 1'b0; A1 = 5'd12; A2 = 5'd9;
    push_exp("rstmid_x12", 32'd0); push_exp("rstmid_x9", 32'd0);
    push_exp("rstmid_wr_count", 32'd0); push_exp("rstmid_ack", 32'd0);
    push_exp("rstmid_rdata", 32'd0);
    @(negedge clk);
    obs = {RD1, RD2, wr_count, 32'(dbg_ack), dbg_rdata};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
    RegWriteW = 1'b1; RD_W = 5'd12; ResultW = 32'hC0C;
    cycle();
    RegWriteW = 1'b0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 5'd12;
    n = 0;
    do begin cycle(); n++; end while (!dbg_ack && n < 10);
    dbg_req = 1'b0;
    push_exp("rstmid_idle_latency", 32'd3); push_exp("rstmid_dbg_x12", 32'hC0C);
    push_exp("rstmid_count_after", 32'd1);
    @(negedge clk);
    obs = {32'(n), dbg_rdata, wr_count};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
    cycle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++) begin
      RegWriteW = 1'($urandom_range(0, 1));
      RD_W      = 5'($urandom_range(0, 31));
      ResultW   = $urandom;
      A1        = 5'($urandom_range(0, 31));
      A2        = (i % 4 == 0) ? RD_W : 5'($urandom_range(0, 31));
      push_exp("b2b_rd1", exp_read(A1, 1'b1)); push_exp("b2b_rd2", exp_read(A2, 1'b1));
      push_exp("b2b_nb_rd2", exp_read(A2, 1'b0));
      @(negedge clk);
      obs = {RD1, RD2, nb_rd2};
      foreach (obs[k]) begin
        e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
        if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
      end
      cycle();
    end
    RegWriteW = 1'b0;
    push_exp("b2b_wr_count", mcount); push_exp("b2b_nb_wr_count", mcount);
    @(negedge clk);
    obs = {wr_count, nb_count};
    foreach (obs[k]) begin
      e = exp_q.pop_front(); nm = name_q.pop_front(); checks++;
      if (obs[k] !== e) begin errors++; $display("FAIL %s: got %h expected %h", nm, obs[k], e); end
    end
  endtask

  initial begin
    rst = 1'b1; RegWriteW = 1'b0; RD_W = '0; ResultW = '0; A1 = '0; A2 = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    foreach (mreg[i]) mreg[i] = '0;
    mcount = '0;
    test_reset();
    test_write_read();
    test_bypass();
    test_x0();
    test_dbg_read();
    test_dbg_contention();
    test_reset_mid_access();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
